// File: rtl/req_rs485_mc_pkg.sv
// Shared definitions for the RS485 request detector: channel states, default codes, helpers.
// No logic of its own; latency and backpressure are properties of the modules that import it.
package req_rs485_mc_pkg;

    localparam int MAX_CH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    // Channel 0 listens for 66 ('B'), channel 1 for 67 ('C').
    localparam logic [15:0] DEF_CODES = {8'd67, 8'd66};

    function automatic logic [2:0] lowest_set(input logic [MAX_CH-1:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/req_rs485_mc_ch.sv
// One request channel: counts matching accepted bytes, then holds ack for ACK_LEN clks.
// ack is registered one clk after the final accept; no backpressure, bytes during ack are dropped.
module req_rs485_mc_ch
    import req_rs485_mc_pkg::*;
#(
    parameter int REQ_CNT = 7,
    parameter int ACK_LEN = 241,
    parameter int GAP_TO  = 0,
    parameter bit STRICT  = 1'b0
) (
    input  logic clk,
    input  logic nRST,
    input  logic accept,
    input  logic match,
    input  logic en,
    output logic ack,
    output logic ack_d
);
    localparam logic [3:0]  CNT_LAST = 4'(REQ_CNT - 1);
    localparam logic [7:0]  ACK_LOAD = 8'(ACK_LEN - 1);
    localparam logic [15:0] GAP_LIM  = 16'(GAP_TO);

    logic [1:0]  state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [7:0]  atmr, atmr_d;
    logic [15:0] gap, gap_d;
    logic        hit, timeout;

    assign hit     = accept & match & en;
    assign timeout = (GAP_TO != 0) && (gap == GAP_LIM);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        atmr_d  = atmr;
        gap_d   = gap;
        case (state)
            ST_IDLE: begin
                cnt_d = '0;
                gap_d = '0;
                if (hit) begin
                    if (REQ_CNT == 1) begin
                        state_d = ST_ACK;
                        atmr_d  = ACK_LOAD;
                    end else begin
                        state_d = ST_COUNT;
                        cnt_d   = 4'd1;
                    end
                end
            end
            ST_COUNT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (hit) begin
                    gap_d = '0;
                    // A match landing on the timeout restarts the run instead of extending it.
                    if (timeout) begin
                        cnt_d = 4'd1;
                    end else if (cnt == CNT_LAST) begin
                        state_d = ST_ACK;
                        cnt_d   = '0;
                        atmr_d  = ACK_LOAD;
                    end else begin
                        cnt_d = cnt + 4'd1;
                    end
                end else if (timeout || (STRICT && accept)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (GAP_TO != 0) begin
                    gap_d = gap + 16'd1;
                end
            end
            ST_ACK: begin
                cnt_d = '0;
                if (atmr == '0) state_d = ST_IDLE;
                else            atmr_d  = atmr - 8'd1;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            atmr  <= '0;
            gap   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            atmr  <= atmr_d;
            gap   <= gap_d;
        end
    end

    assign ack   = (state == ST_ACK);
    assign ack_d = (state_d == ST_ACK);

endmodule

// File: rtl/req_rs485_mc.sv
// Multi-channel request detector on the RS485 byte stream; edge-detects rValid, fans out to channels.
// ack/ackAny/lastCh/TEST are registered one clk after the accept; no backpressure on the receiver.
module req_rs485_mc
    import req_rs485_mc_pkg::*;
#(
    parameter int                N_CH    = 2,
    parameter logic [N_CH*8-1:0] CODES   = DEF_CODES,
    parameter int                REQ_CNT = 7,
    parameter int                ACK_LEN = 241,
    parameter int                GAP_TO  = 0,
    parameter bit                STRICT  = 1'b0
) (
    input  logic            clk,
    input  logic            nRST,
    input  logic            rValid,
    input  logic [7:0]      dataMFK,
    input  logic [N_CH-1:0] enMask,
    output logic [N_CH-1:0] ack,
    output logic            ackAny,
    output logic [2:0]      lastCh,
    output logic            TEST
);
    logic            rvalid_q;
    logic            accept;
    logic [N_CH-1:0] match;
    logic [N_CH-1:0] ack_d;
    logic [N_CH-1:0] rise;

    assign accept = rValid & ~rvalid_q;
    assign rise   = ack_d & ~ack;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign match[i] = (dataMFK == CODES[8*i +: 8]);

        req_rs485_mc_ch #(
            .REQ_CNT (REQ_CNT),
            .ACK_LEN (ACK_LEN),
            .GAP_TO  (GAP_TO),
            .STRICT  (STRICT)
        ) u_ch (
            .clk    (clk),
            .nRST   (nRST),
            .accept (accept),
            .match  (match[i]),
            .en     (enMask[i]),
            .ack    (ack[i]),
            .ack_d  (ack_d[i])
        );
    end

    // ackAny and lastCh follow the channels' next-state so they line up with ack.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            rvalid_q <= 1'b0;
            TEST     <= 1'b0;
            ackAny   <= 1'b0;
            lastCh   <= '0;
        end else begin
            rvalid_q <= rValid;
            TEST     <= accept & (|(match & enMask));
            ackAny   <= |ack_d;
            if (|rise) lastCh <= lowest_set(MAX_CH'(rise));
        end
    end

endmodule

// File: tb/tb_req_rs485_mc.sv
// Bench for req_rs485_mc: four parameter variants share one stimulus stream and an event-time model.
module tb_req_rs485_mc;
    localparam int NI   = 4;
    localparam int ACKL = 241;
    localparam int REQ  = 7;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       rValid = 1'b0;
    logic [7:0] dataMFK = 8'd0;
    logic [1:0] enMask = 2'b11;

    logic [1:0] ack_o  [NI];
    logic       any_o  [NI];
    logic [2:0] lc_o   [NI];
    logic       test_o [NI];

    always #5 clk = ~clk;

    // 0: defaults, 1: GAP_TO=100, 2: STRICT=1, 3: both channels on code 66
    for (genvar g = 0; g < NI; g++) begin : g_dut
        req_rs485_mc #(
            .N_CH    (2),
            .CODES   ((g == 3) ? 16'h4242 : 16'h4342),
            .REQ_CNT (REQ),
            .ACK_LEN (ACKL),
            .GAP_TO  ((g == 1) ? 100 : 0),
            .STRICT  (g == 2)
        ) u_dut (
            .clk     (clk),
            .nRST    (nRST),
            .rValid  (rValid),
            .dataMFK (dataMFK),
            .enMask  (enMask),
            .ack     (ack_o[g]),
            .ackAny  (any_o[g]),
            .lastCh  (lc_o[g]),
            .TEST    (test_o[g])
        );
    end

    int         cfg_gap    [NI]    = '{0, 100, 0, 0};
    bit         cfg_strict [NI]    = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] cfg_code   [NI][2] = '{'{8'd66, 8'd67}, '{8'd66, 8'd67}, '{8'd66, 8'd67}, '{8'd66, 8'd66}};

    // Model: per channel a running match count, the edge of the last counted match and the edge the ack started.
    int         m_cnt  [NI][2];
    int         m_last [NI][2];
    int         m_ae   [NI][2];
    logic [2:0] m_lc   [NI];
    logic       m_test [NI];
    logic       m_rvp;
    int         cyc = 0;

    int checks = 0;
    int errors = 0;

    int         rise_cnt [NI][2];
    int         rise_cyc [NI][2];
    int         wid      [NI][2];
    int         last_wid [NI][2];
    logic       prev_ack [NI][2];
    int         tcnt     [NI];
    int         acc_q[$];

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < 2; c++) begin
                m_cnt[i][c]  = 0;
                m_last[i][c] = 0;
                m_ae[i][c]   = -100000;
            end
            m_lc[i]   = 3'd0;
            m_test[i] = 1'b0;
        end
        m_rvp = 1'b0;
    endtask

    task automatic model_step();
        bit acc, m, busy, anyhit, lcset;
        acc   = rValid && !m_rvp;
        m_rvp = rValid;
        for (int i = 0; i < NI; i++) begin
            anyhit = 1'b0;
            lcset  = 1'b0;
            for (int c = 0; c < 2; c++) begin
                m    = (dataMFK == cfg_code[i][c]);
                busy = (cyc >= m_ae[i][c] + 1) && (cyc <= m_ae[i][c] + ACKL);
                if (acc && m && enMask[c]) anyhit = 1'b1;
                if (!busy) begin
                    if (!enMask[c]) begin
                        m_cnt[i][c] = 0;
                    end else if (acc && m) begin
                        if (m_cnt[i][c] > 0 && cfg_gap[i] != 0 && (cyc - m_last[i][c]) > cfg_gap[i])
                            m_cnt[i][c] = 0;
                        m_cnt[i][c]  = m_cnt[i][c] + 1;
                        m_last[i][c] = cyc;
                        if (m_cnt[i][c] == REQ) begin
                            m_ae[i][c]  = cyc;
                            m_cnt[i][c] = 0;
                        end
                    end else if (acc && cfg_strict[i]) begin
                        m_cnt[i][c] = 0;
                    end
                end
                if (m_ae[i][c] == cyc && !lcset) begin
                    m_lc[i] = 3'(c);
                    lcset   = 1'b1;
                end
            end
            m_test[i] = anyhit;
        end
    endtask

    function automatic logic [6:0] exp_vec(input int i);
        logic [1:0] a;
        for (int c = 0; c < 2; c++)
            a[c] = (cyc >= m_ae[i][c]) && (cyc <= m_ae[i][c] + ACKL - 1);
        return {a, |a, m_lc[i], m_test[i]};
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!nRST) model_reset();
        else       model_step();
    end

    always @(negedge nRST) model_reset();

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            logic [6:0] got, ex;
            got = {ack_o[i], any_o[i], lc_o[i], test_o[i]};
            ex  = exp_vec(i);
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL model inst%0d cyc %0d: {ack,ackAny,lastCh,TEST} got %b expected %b", i, cyc, got, ex);
            end
            for (int c = 0; c < 2; c++) begin
                if (ack_o[i][c] && !prev_ack[i][c]) begin
                    rise_cnt[i][c]++;
                    rise_cyc[i][c] = cyc;
                    wid[i][c] = 0;
                end
                if (ack_o[i][c]) wid[i][c]++;
                if (!ack_o[i][c] && prev_ack[i][c]) last_wid[i][c] = wid[i][c];
                prev_ack[i][c] = ack_o[i][c];
            end
            if (test_o[i]) tcnt[i]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b, input int n, input int hi, input int lo);
        for (int k = 0; k < n; k++) begin
            dataMFK = b;
            rValid  = 1'b1;
            acc_q.push_back(cyc + 1);
            repeat (hi) tick();
            rValid = 1'b0;
            repeat (lo) tick();
        end
    endtask

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        rValid = 1'b0;
        nRST   = 1'b0;
        repeat (3) tick();
        nRST = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [7:0] code;
        int         n;
        int         hi;
        int         lo;
        logic [1:0] en;
        int         rise0;
        int         rise1;
        int         lastch;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int b0, b1, b2, b3a, b3b, t0;
        logic [7:0] rb;
        model_reset();
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < 2; c++) prev_ack[i][c] = 1'b0;

        tbl[0] = '{8'd66,  7, 3, 5, 2'b11, 1, 0, 0};
        tbl[1] = '{8'd67,  6, 3, 5, 2'b11, 0, 0, 0};
        tbl[2] = '{8'd67,  1, 1, 1, 2'b11, 0, 1, 1};
        tbl[3] = '{8'd66,  6, 2, 2, 2'b11, 0, 0, 1};
        tbl[4] = '{8'd66,  1, 2, 2, 2'b10, 0, 0, 1};
        tbl[5] = '{8'd66,  6, 2, 2, 2'b11, 0, 0, 1};
        tbl[6] = '{8'd66,  1, 2, 2, 2'b11, 1, 0, 0};
        tbl[7] = '{8'h55, 10, 2, 2, 2'b11, 0, 0, 0};
        tbl[8] = '{8'd66, 14, 2, 2, 2'b11, 1, 0, 0};
        tbl[9] = '{8'd66,  7, 1, 1, 2'b11, 1, 0, 0};

        tick();
        tick();
        for (int i = 0; i < NI; i++)
            check($sformatf("reset outputs inst%0d", i), int'({ack_o[i], any_o[i], lc_o[i], test_o[i]}), 0);
        nRST = 1'b1;
        tick();

        for (int r = 0; r < 10; r++) begin
            b0 = rise_cnt[0][0];
            b1 = rise_cnt[0][1];
            acc_q.delete();
            enMask = tbl[r].en;
            send(tbl[r].code, tbl[r].n, tbl[r].hi, tbl[r].lo);
            enMask = 2'b11;
            repeat (260) tick();
            check($sformatf("vec%0d ack0 rises", r), rise_cnt[0][0] - b0, tbl[r].rise0);
            check($sformatf("vec%0d ack1 rises", r), rise_cnt[0][1] - b1, tbl[r].rise1);
            check($sformatf("vec%0d lastCh", r), int'(lc_o[0]), tbl[r].lastch);
            if (r == 0) begin
                check("ack0 rise edge vs 7th accept", rise_cyc[0][0], acc_q[6]);
                check("ack0 width", last_wid[0][0], ACKL);
            end
        end

        // rValid held high: one accept only
        do_reset();
        t0 = tcnt[0];
        dataMFK = 8'd66;
        rValid  = 1'b1;
        repeat (50) tick();
        rValid = 1'b0;
        repeat (5) tick();
        check("held rValid TEST pulses", tcnt[0] - t0, 1);
        b0 = rise_cnt[0][0];
        acc_q.delete();
        send(8'd66, 6, 3, 5);
        repeat (5) tick();
        check("held rValid counted once: rises", rise_cnt[0][0] - b0, 1);
        check("held rValid counted once: edge", rise_cyc[0][0], acc_q[5]);
        repeat (260) tick();

        // gap timeout on instance 1, none on instance 0
        do_reset();
        send(8'd66, 3, 3, 5);
        repeat (150) tick();
        acc_q.delete();
        b0 = rise_cnt[0][0];
        b1 = rise_cnt[1][0];
        send(8'd66, 7, 3, 5);
        repeat (5) tick();
        check("gap inst1 rises", rise_cnt[1][0] - b1, 1);
        check("gap inst1 rise edge", rise_cyc[1][0], acc_q[6]);
        check("nogap inst0 rise edge", rise_cyc[0][0], acc_q[3]);
        check("nogap inst0 rises", rise_cnt[0][0] - b0, 1);
        repeat (260) tick();

        // strict vs lenient, plus duplicated codes
        do_reset();
        b0  = rise_cnt[0][0];
        b2  = rise_cnt[2][0];
        b3a = rise_cnt[3][0];
        b3b = rise_cnt[3][1];
        send(8'd66, 4, 2, 2);
        send(8'h55, 1, 2, 2);
        acc_q.delete();
        send(8'd66, 7, 2, 2);
        repeat (5) tick();
        check("strict inst2 rises", rise_cnt[2][0] - b2, 1);
        check("strict inst2 rise edge", rise_cyc[2][0], acc_q[6]);
        check("lenient inst0 rise edge", rise_cyc[0][0], acc_q[2]);
        check("lenient inst0 rises", rise_cnt[0][0] - b0, 1);
        check("dup inst3 ch0 rise edge", rise_cyc[3][0], acc_q[2]);
        check("dup inst3 ch1 rise edge", rise_cyc[3][1], acc_q[2]);
        check("dup inst3 ch0 rises", rise_cnt[3][0] - b3a, 1);
        check("dup inst3 ch1 rises", rise_cnt[3][1] - b3b, 1);
        check("dup inst3 lastCh", int'(lc_o[3]), 0);
        repeat (260) tick();

        // reset in the middle of an ack
        do_reset();
        acc_q.delete();
        send(8'd66, 7, 3, 5);
        while (cyc < acc_q[6] + 99) tick();
        check("ack high before mid reset", int'(ack_o[0][0]), 1);
        nRST = 1'b0;
        #1;
        check("ack after mid reset", int'(ack_o[0]), 0);
        check("ackAny after mid reset", int'(any_o[0]), 0);
        repeat (2) tick();
        nRST = 1'b1;
        tick();
        b0 = rise_cnt[0][0];
        acc_q.delete();
        send(8'd66, 6, 3, 5);
        repeat (10) tick();
        check("after reset 6 bytes no ack", rise_cnt[0][0] - b0, 0);
        send(8'd66, 1, 3, 5);
        check("after reset 7th byte acks", rise_cnt[0][0] - b0, 1);
        check("after reset rise edge", rise_cyc[0][0], acc_q[6]);
        repeat (260) tick();

        // randomized traffic checked by the model every clk
        do_reset();
        for (int it = 0; it < 200; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4)       rb = 8'd66;
            else if (r < 7)  rb = 8'd67;
            else if (r == 7) rb = 8'h55;
            else             rb = 8'($urandom);
            enMask = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            send(rb, 1, $urandom_range(1, 4), $urandom_range(1, 6));
            if ($urandom_range(0, 9) == 0) repeat ($urandom_range(90, 200)) tick();
            if ($urandom_range(0, 49) == 0) do_reset();
        end
        enMask = 2'b11;
        repeat (260) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
